io_port_hub: RTL and testbench

- Sits between the CPU core's byte-wide memory bus and the RAM and UART blocks.
- Decodes the address:
  - `mem_a[17:16]==2'b11` selects I/O.
  - Anything else goes to the 128KB RAM.
- For I/O it provides:
  - a buffered UART TX path with the `io_buffer_full` back-pressure flag;
  - the UART RX read path;
  - the free-running clock counter at 0x30004;
  - the program-stop sequence.
- Returns read data one cycle after the request, matching the core's memory timing contract.

---
 rtl/io_port_hub_pkg.sv | 28 ++
 rtl/io_port_hub_if.sv | 45 ++++
 rtl/io_port_hub_tx_fifo.sv | 66 ++++++
 rtl/io_port_hub.sv | 179 +++++++++++++++++
 tb/tb_io_port_hub.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/io_port_hub_pkg.sv
// ---------------------------------------------------------------------------
// io_port_hub_pkg
// Shared constants and types for the I/O port hub:
//   - I/O window base address and the offsets of its two registers
//   - the address bits that select the I/O window
//   - FSM state encoding for the program-stop sequence
//   - byte_of(): little-endian byte extraction from a 32-bit word
// ---------------------------------------------------------------------------
package io_port_hub_pkg;

    localparam logic [31:0] IO_BASE       = 32'h0003_0000;
    localparam logic [2:0]  IO_IN_OUT     = 3'h0;
    localparam logic [2:0]  IO_CLOCK_STOP = 3'h4;

    // cpu_a[17:16] of the I/O window (2'b11); anything else is RAM.
    localparam logic [1:0]  IO_SEL        = IO_BASE[17:16];

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } hub_state_e;

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/io_port_hub_if.sv
// ---------------------------------------------------------------------------
// io_port_hub_if
// Bus bundle around the I/O port hub.
//   CPU side : rdy_in, cpu_a, cpu_dout, cpu_wr -> hub ; cpu_din, io_buffer_full <- hub
//   RAM side : ram_a, ram_we, ram_dout <- hub ; ram_din -> hub (1-cycle latency)
//   UART side: tx_data, tx_valid, rx_pop <- hub ; tx_ready, rx_data, rx_valid -> hub
//   Status   : halted <- hub
// modport master: the environment (core, RAM, UART); modport slave: the hub.
// ---------------------------------------------------------------------------
interface io_port_hub_if;

    logic        rdy_in;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;

    logic [16:0] ram_a;
    logic        ram_we;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;

    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;

    logic        halted;

    modport master (
        output rdy_in, cpu_a, cpu_dout, cpu_wr, ram_din, tx_ready, rx_data, rx_valid,
        input  cpu_din, io_buffer_full, ram_a, ram_we, ram_dout, tx_data, tx_valid,
               rx_pop, halted
    );

    modport slave (
        input  rdy_in, cpu_a, cpu_dout, cpu_wr, ram_din, tx_ready, rx_data, rx_valid,
        output cpu_din, io_buffer_full, ram_a, ram_we, ram_dout, tx_data, tx_valid,
               rx_pop, halted
    );

endinterface

// File: rtl/io_port_hub_tx_fifo.sv
// ---------------------------------------------------------------------------
// io_tx_fifo
// Synchronous byte FIFO, 2**DEPTH_BIT entries, async active-low reset.
//   push/push_data : write side; a push into a full FIFO is dropped
//   pop/rd_data    : read side, rd_data is the head entry (valid when count!=0)
//   count          : current occupancy
//   count_nxt      : occupancy after this cycle's push/pop
// ---------------------------------------------------------------------------
module io_tx_fifo #(
    parameter int unsigned DEPTH_BIT = 3
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 push,
    input  logic [7:0]           push_data,
    input  logic                 pop,
    output logic [7:0]           rd_data,
    output logic [DEPTH_BIT:0]   count,
    output logic [DEPTH_BIT:0]   count_nxt
);

    localparam logic [DEPTH_BIT:0] FULL_CNT = {1'b1, {DEPTH_BIT{1'b0}}};

    logic [7:0]           mem_q [0:(1 << DEPTH_BIT) - 1];
    logic [DEPTH_BIT-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BIT-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BIT:0]   count_q, count_d;
    logic                 push_ok, pop_ok;

    always_comb begin
        push_ok  = push && (count_q != FULL_CNT);
        pop_ok   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted in.
    always_ff @(posedge clk_in) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

    assign rd_data   = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign count_nxt = count_d;

endmodule

// File: rtl/io_port_hub.sv
// ---------------------------------------------------------------------------
// io_port_hub
// Address decoder between the core's byte bus, the 128KB RAM and the UART.
// cpu_a[17:16]==2'b11 selects I/O; everything else is RAM.
//   clk_in : system clock
//   rst_in : asynchronous active-low reset
//   bus    : io_port_hub_if.slave (CPU, RAM and UART signals, halted)
// I/O map (cpu_a[2:0]):
//   0     read: UART RX byte (pops it) or 0x00 ; write: push non-zero byte to TX FIFO
//   4..7  read: free-running cycle counter, little-endian
//   4     write: push NUL, drain the TX FIFO, then halt
// Read data returns the cycle after the request.
// Optional: define IO_CLOCK_SNAPSHOT_EN so a read of offset 4 latches the
// whole counter and offsets 5..7 return bytes of that snapshot.
// ---------------------------------------------------------------------------
module io_port_hub
    import io_port_hub_pkg::*;
#(
    parameter int unsigned TX_DEPTH_BIT = 3,
    parameter int unsigned FULL_MARGIN  = 2
) (
    input  logic         clk_in,
    input  logic         rst_in,
    io_port_hub_if.slave bus
);

    localparam int unsigned        CW         = TX_DEPTH_BIT + 1;
    localparam logic [CW-1:0]      FULL_CNT   = {1'b1, {TX_DEPTH_BIT{1'b0}}};
    localparam logic [CW-1:0]      MARGIN_CNT = CW'(FULL_MARGIN);

    hub_state_e  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        rd_pend_q, rd_pend_d;
    logic        sel_io_q, sel_io_d;
    logic [7:0]  io_byte_q, io_byte_d;
    logic [7:0]  din_hold_q, din_hold_d;
    logic        full_q, full_d;

    logic        is_io_acc;
    logic [2:0]  io_off;
    logic        rd_acc, wr_acc;
    logic [7:0]  io_byte;
    logic        rx_pop_c;
    logic        push;
    logic [7:0]  push_data;
    logic        tx_pop;
    logic [7:0]  cpu_din_c;
    logic [7:0]  fifo_rd_data;
    logic [CW-1:0] fifo_count, fifo_count_nxt;
    logic        unused_addr;

`ifdef IO_CLOCK_SNAPSHOT_EN
    logic [31:0] snap_q, snap_d;
`endif

    assign unused_addr = ^bus.cpu_a[31:18];

    assign is_io_acc = (bus.cpu_a[17:16] == IO_SEL);
    assign io_off    = bus.cpu_a[2:0];
    assign rd_acc    = bus.rdy_in && !bus.cpu_wr;
    assign wr_acc    = bus.rdy_in && bus.cpu_wr;

    // I/O read byte selection.
    always_comb begin
        io_byte  = '0;
        rx_pop_c = 1'b0;
        if (io_off == IO_IN_OUT) begin
            if (bus.rx_valid) io_byte = bus.rx_data;
            rx_pop_c = rd_acc && is_io_acc && bus.rx_valid;
        end else if (io_off[2]) begin
`ifdef IO_CLOCK_SNAPSHOT_EN
            if (io_off[1:0] == 2'd0) io_byte = cnt_q[7:0];
            else                     io_byte = byte_of(snap_q, io_off[1:0]);
`else
            io_byte = byte_of(cnt_q, io_off[1:0]);
`endif
        end
    end

`ifdef IO_CLOCK_SNAPSHOT_EN
    always_comb begin
        snap_d = snap_q;
        if (rd_acc && is_io_acc && (io_off == IO_CLOCK_STOP)) snap_d = cnt_q;
    end
`endif

    // Write decode and program-stop FSM.
    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        push_data = bus.cpu_dout;
        case (state_q)
            ST_RUN: begin
                if (wr_acc && is_io_acc) begin
                    if (io_off == IO_IN_OUT) begin
                        push = (bus.cpu_dout != '0);
                    end else if (io_off == IO_CLOCK_STOP) begin
                        push      = 1'b1;
                        push_data = '0;
                        state_d   = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if ((fifo_count == '0) && !push) state_d = ST_HALTED;
            end
            default: state_d = ST_HALTED;
        endcase
    end

    // Read return: a registered I/O byte or the RAM's own 1-cycle data; when
    // no read was accepted last cycle the previous value is held.
    always_comb begin
        cpu_din_c  = rd_pend_q ? (sel_io_q ? io_byte_q : bus.ram_din) : din_hold_q;
        din_hold_d = cpu_din_c;
        rd_pend_d  = rd_acc;
        sel_io_d   = sel_io_q;
        io_byte_d  = io_byte_q;
        if (rd_acc) begin
            sel_io_d  = is_io_acc;
            io_byte_d = io_byte;
        end
        cnt_d  = cnt_q + 32'd1;
        tx_pop = bus.tx_valid && bus.tx_ready;
        full_d = (FULL_CNT - fifo_count_nxt) <= MARGIN_CNT;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            rd_pend_q  <= 1'b0;
            sel_io_q   <= 1'b0;
            io_byte_q  <= '0;
            din_hold_q <= '0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_pend_q  <= rd_pend_d;
            sel_io_q   <= sel_io_d;
            io_byte_q  <= io_byte_d;
            din_hold_q <= din_hold_d;
            full_q     <= full_d;
        end
    end

`ifdef IO_CLOCK_SNAPSHOT_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) snap_q <= '0;
        else         snap_q <= snap_d;
    end
`endif

    io_tx_fifo #(
        .DEPTH_BIT (TX_DEPTH_BIT)
    ) u_tx_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (push),
        .push_data (push_data),
        .pop       (tx_pop),
        .rd_data   (fifo_rd_data),
        .count     (fifo_count),
        .count_nxt (fifo_count_nxt)
    );

    assign bus.ram_a          = bus.cpu_a[16:0];
    assign bus.ram_dout       = bus.cpu_dout;
    assign bus.ram_we         = wr_acc && !is_io_acc && (state_q != ST_HALTED);
    // Gated by reset so no RX byte is consumed while the hub is held in reset.
    assign bus.rx_pop         = rx_pop_c && rst_in;
    assign bus.cpu_din        = cpu_din_c;
    assign bus.tx_data        = fifo_rd_data;
    assign bus.tx_valid       = (fifo_count != '0);
    assign bus.io_buffer_full = full_q;
    assign bus.halted         = (state_q == ST_HALTED);

endmodule

// File: tb/tb_io_port_hub.sv
module tb_io_port_hub;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk_in = ~clk_in;

    io_port_hub_if bus ();

    io_port_hub #(
        .TX_DEPTH_BIT (3),
        .FULL_MARGIN  (2)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    // RAM model with 1-cycle read latency.
    logic [7:0] ram_mem [0:131071];
    always @(posedge clk_in) begin
        if (bus.ram_we) ram_mem[bus.ram_a] <= bus.ram_dout;
        bus.ram_din <= ram_mem[bus.ram_a];
    end

    // UART TX observer.
    logic [7:0] tx_seen [$];
    always @(posedge clk_in) begin
        if (rst_in && bus.tx_valid && bus.tx_ready) tx_seen.push_back(bus.tx_data);
    end

    // Reference cycle counter.
    logic [31:0] tb_cnt;
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) tb_cnt <= '0;
        else         tb_cnt <= tb_cnt + 32'd1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] seen_at(input int i);
        if (tx_seen.size() > i) return {24'd0, tx_seen[i]};
        return 32'hDEAD;
    endfunction

    task automatic set_bus(input logic rdy, input logic wr, input logic [31:0] a, input logic [7:0] d);
        bus.rdy_in   = rdy;
        bus.cpu_wr   = wr;
        bus.cpu_a    = a;
        bus.cpu_dout = d;
    endtask

    task automatic bus_cycle(input logic rdy, input logic wr, input logic [31:0] a, input logic [7:0] d);
        @(negedge clk_in);
        set_bus(rdy, wr, a, d);
        @(posedge clk_in);
        #1;
    endtask

    typedef struct {
        logic        rdy;
        logic        wr;
        logic [31:0] a;
        logic [7:0]  d;
        logic        rxv;
        logic [7:0]  rxd;
        logic        exp_we;
        logic        exp_pop;
        logic        chk_din;
        logic [7:0]  exp_din;
    } vec_t;

    vec_t vec [16];

    initial begin
        logic [31:0] c0, live, expw;

        //              rdy  wr   addr          d      rxv  rxd    we   pop  chk  din
        vec[0]  = '{1'b1, 1'b1, 32'h0000_0100, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
        vec[1]  = '{1'b1, 1'b0, 32'h0000_0100, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h5A};
        vec[2]  = '{1'b0, 1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h37, 1'b0, 1'b0, 1'b1, 8'h5A};
        vec[3]  = '{1'b0, 1'b1, 32'h0000_0200, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h5A};
        vec[4]  = '{1'b1, 1'b1, 32'h0003_0000, 8'h41, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        vec[5]  = '{1'b1, 1'b1, 32'h0003_0000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        vec[6]  = '{1'b1, 1'b1, 32'h0003_0000, 8'h42, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        vec[7]  = '{1'b1, 1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h37, 1'b0, 1'b1, 1'b1, 8'h37};
        vec[8]  = '{1'b1, 1'b0, 32'h0003_0000, 8'h00, 1'b0, 8'h99, 1'b0, 1'b0, 1'b1, 8'h00};
        vec[9]  = '{1'b1, 1'b0, 32'h0003_0001, 8'h00, 1'b1, 8'h37, 1'b0, 1'b0, 1'b1, 8'h00};
        vec[10] = '{1'b1, 1'b1, 32'h0002_FFFF, 8'hC3, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
        vec[11] = '{1'b1, 1'b1, 32'h0001_FFFF, 8'h7E, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
        vec[12] = '{1'b1, 1'b0, 32'h0001_FFFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h7E};
        vec[13] = '{1'b1, 1'b0, 32'h0000_FFFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hC3};
        vec[14] = '{1'b1, 1'b0, 32'h0003_0007, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
        vec[15] = '{1'b1, 1'b1, 32'h0003_0003, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};

        // Reset state, with an RX read presented while held in reset.
        bus.tx_ready = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h37;
        set_bus(1'b1, 1'b0, 32'h0003_0000, 8'h00);
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_cpu_din", bus.cpu_din, 32'h0);
        check("rst_tx_valid", bus.tx_valid, 32'h0);
        check("rst_rx_pop", bus.rx_pop, 32'h0);
        check("rst_halted", bus.halted, 32'h0);
        check("rst_full", bus.io_buffer_full, 32'h0);

        // Counter byte 0 read in the first cycle after release.
        @(negedge clk_in);
        rst_in = 1'b1;
        bus.rx_valid = 1'b0;
        set_bus(1'b1, 1'b0, 32'h0003_0004, 8'h00);
        @(posedge clk_in);
        #1;
        check("cnt_after_rst", bus.cpu_din, 32'h0);

        // Table of single-cycle transactions.
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_in);
            set_bus(vec[i].rdy, vec[i].wr, vec[i].a, vec[i].d);
            bus.rx_valid = vec[i].rxv;
            bus.rx_data  = vec[i].rxd;
            #1;
            check($sformatf("v%0d_ram_we", i), bus.ram_we, vec[i].exp_we);
            check($sformatf("v%0d_rx_pop", i), bus.rx_pop, vec[i].exp_pop);
            @(posedge clk_in);
            #1;
            if (vec[i].chk_din) check($sformatf("v%0d_cpu_din", i), bus.cpu_din, vec[i].exp_din);
        end
        bus.rx_valid = 1'b0;
        bus_cycle(1'b0, 1'b0, 32'h0, 8'h00);
        repeat (3) bus_cycle(1'b0, 1'b0, 32'h0, 8'h00);
        check("tx_nul_skip_cnt", tx_seen.size(), 32'd2);
        check("tx_byte0", seen_at(0), 32'h41);
        check("tx_byte1", seen_at(1), 32'h42);

        // Four consecutive counter byte reads.
        c0 = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            set_bus(1'b1, 1'b0, 32'h0003_0004 + i, 8'h00);
            if (i == 0) c0 = tb_cnt;
            live = tb_cnt;
            @(posedge clk_in);
            #1;
`ifdef IO_CLOCK_SNAPSHOT_EN
            expw = c0 >> (8 * i);
`else
            expw = live >> (8 * i);
`endif
            check($sformatf("cnt_byte%0d", i), bus.cpu_din, {24'd0, expw[7:0]});
        end

        // Back-pressure flag: six pushes with the UART stalled.
        bus.tx_ready = 1'b0;
        @(negedge clk_in);
        tx_seen.delete();
        for (int i = 0; i < 6; i++) begin
            bus_cycle(1'b1, 1'b1, 32'h0003_0000, 8'h11 + 8'(i));
            check($sformatf("full_after_push%0d", i + 1), bus.io_buffer_full, (i == 5) ? 32'h1 : 32'h0);
        end
        @(negedge clk_in);
        set_bus(1'b0, 1'b0, 32'h0, 8'h00);
        bus.tx_ready = 1'b1;
        @(posedge clk_in);
        #1;
        check("full_after_pop", bus.io_buffer_full, 32'h0);
        for (int k = 0; k < 20 && bus.tx_valid; k++) bus_cycle(1'b0, 1'b0, 32'h0, 8'h00);
        check("full_drain_done", bus.tx_valid, 32'h0);
        check("full_drain_cnt", tx_seen.size(), 32'd6);
        check("full_drain_first", seen_at(0), 32'h11);
        check("full_drain_last", seen_at(5), 32'h16);

        // Reset mid-stream with three bytes queued.
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) bus_cycle(1'b1, 1'b1, 32'h0003_0000, 8'h21 + 8'(i));
        check("mid_tx_valid_pre", bus.tx_valid, 32'h1);
        @(negedge clk_in);
        set_bus(1'b0, 1'b0, 32'h0, 8'h00);
        rst_in = 1'b0;
        #1;
        check("mid_rst_tx_valid", bus.tx_valid, 32'h0);
        check("mid_rst_full", bus.io_buffer_full, 32'h0);
        check("mid_rst_halted", bus.halted, 32'h0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        set_bus(1'b1, 1'b0, 32'h0003_0004, 8'h00);
        @(posedge clk_in);
        #1;
        check("mid_cnt_after_rst", bus.cpu_din, 32'h0);
        check("mid_tx_valid_post", bus.tx_valid, 32'h0);

        // Program stop: two bytes pending, then drain, NUL and halt.
        @(negedge clk_in);
        tx_seen.delete();
        bus_cycle(1'b1, 1'b1, 32'h0003_0000, 8'h61);
        bus_cycle(1'b1, 1'b1, 32'h0003_0000, 8'h62);
        bus_cycle(1'b1, 1'b1, 32'h0003_0004, 8'hFF);
        check("drain_not_halted", bus.halted, 32'h0);
        bus_cycle(1'b1, 1'b1, 32'h0003_0000, 8'h63);
        @(negedge clk_in);
        set_bus(1'b1, 1'b1, 32'h0000_0300, 8'h99);
        #1;
        check("drain_ram_we", bus.ram_we, 32'h1);
        @(negedge clk_in);
        set_bus(1'b0, 1'b0, 32'h0, 8'h00);
        bus.tx_ready = 1'b1;
        for (int k = 0; k < 20 && !bus.halted; k++) begin
            @(posedge clk_in);
            #1;
        end
        check("halt_reached", bus.halted, 32'h1);
        check("halt_tx_cnt", tx_seen.size(), 32'd3);
        check("halt_tx0", seen_at(0), 32'h61);
        check("halt_tx1", seen_at(1), 32'h62);
        check("halt_tx2", seen_at(2), 32'h00);
        bus_cycle(1'b1, 1'b1, 32'h0003_0000, 8'h64);
        @(negedge clk_in);
        set_bus(1'b1, 1'b1, 32'h0000_0100, 8'h00);
        #1;
        check("halt_ram_we", bus.ram_we, 32'h0);
        bus_cycle(1'b1, 1'b0, 32'h0000_0100, 8'h00);
        check("halt_ram_read", bus.cpu_din, 32'h5A);
        repeat (3) bus_cycle(1'b0, 1'b0, 32'h0, 8'h00);
        check("halt_tx_valid", bus.tx_valid, 32'h0);
        check("halt_tx_cnt_after", tx_seen.size(), 32'd3);
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        check("halt_cleared_by_rst", bus.halted, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
